// File: rtl/cga_intr_pkg.sv
// cga_intr_pkg: shared types, IDENT field positions and IDENT packing helper
// for the CGA interrupt controller vector-acknowledge responder.
package cga_intr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DRIVE,
        ST_CLEAR,
        ST_WAIT_REL
    } state_e;

    localparam int IDENT_LVL      = 15;
    localparam int IDENT_EMPTY    = 14;
    localparam int IDENT_UNSTABLE = 13;
    localparam int IDENT_STAT_LSB = 4;
    localparam int IDENT_VEC_LSB  = 0;

    function automatic logic [15:0] make_ident(
        input logic       lvl,
        input logic       flag,
        input logic       unstable,
        input logic [2:0] stat,
        input logic [2:0] vec
    );
        logic [15:0] w;
        w                          = '0;
        w[IDENT_LVL]               = lvl;
        w[IDENT_EMPTY]             = ~flag;
        w[IDENT_UNSTABLE]          = unstable;
        w[IDENT_STAT_LSB +: 3]     = stat;
        w[IDENT_VEC_LSB +: 3]      = vec;
        return w;
    endfunction

endpackage

// File: rtl/cga_intr_cntlr_vecack_snap.sv
// cga_intr_cntlr_vecack_snap: level mux, snapshot registers and live/snapshot compare.
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cap_i                    load the snapshot from the live tuple
//   new_i                    with cap_i: also latch the level from sel_i
//   sel_i                    level select (1 = HI, 0 = LO)
//   hif_i/lof_i, hivec_i/lovec_i, histat_i/lostat_i   per-level inputs
//   lvl_o, flag_o, vec_o     snapshot level, flag, vector
//   live_flag_o/vec_o/stat_o live tuple of the selected level
//   match_o                  live tuple equals the snapshot
module cga_intr_cntlr_vecack_snap
    import cga_intr_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cap_i,
    input  logic       new_i,
    input  logic       sel_i,
    input  logic       hif_i,
    input  logic       lof_i,
    input  logic [2:0] hivec_i,
    input  logic [2:0] lovec_i,
    input  logic [2:0] histat_i,
    input  logic [2:0] lostat_i,
    output logic       lvl_o,
    output logic       flag_o,
    output logic [2:0] vec_o,
    output logic       live_flag_o,
    output logic [2:0] live_vec_o,
    output logic [2:0] live_stat_o,
    output logic       match_o
);

    logic       lvl_q, lvl_d;
    logic       flag_q, flag_d;
    logic [2:0] vec_q, vec_d;
    logic [2:0] stat_q, stat_d;
    logic       lvl_sel;

    // On a fresh capture the level comes straight from SEL; afterwards the
    // latched level steers the mux so later SEL changes are ignored.
    assign lvl_sel     = new_i ? sel_i : lvl_q;
    assign live_flag_o = lvl_sel ? hif_i    : lof_i;
    assign live_vec_o  = lvl_sel ? hivec_i  : lovec_i;
    assign live_stat_o = lvl_sel ? histat_i : lostat_i;

    assign match_o = {live_flag_o, live_vec_o, live_stat_o} == {flag_q, vec_q, stat_q};

    always_comb begin
        lvl_d  = cap_i ? lvl_sel     : lvl_q;
        flag_d = cap_i ? live_flag_o : flag_q;
        vec_d  = cap_i ? live_vec_o  : vec_q;
        stat_d = cap_i ? live_stat_o : stat_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lvl_q  <= 1'b0;
            flag_q <= 1'b0;
            vec_q  <= 3'd0;
            stat_q <= 3'd0;
        end else begin
            lvl_q  <= lvl_d;
            flag_q <= flag_d;
            vec_q  <= vec_d;
            stat_q <= stat_d;
        end
    end

    assign lvl_o  = lvl_q;
    assign flag_o = flag_q;
    assign vec_o  = vec_q;

endmodule

// File: rtl/cga_intr_cntlr_vecack.sv
// cga_intr_cntlr_vecack: interrupt vector acknowledge responder.
//   MCLK, RESET_N            clock, asynchronous active-low reset
//   REQ, SEL                 acknowledge request and level select from microcode
//   HIF/LOF, HIVEC_2_0/LOVEC_2_0, HISTAT_2_0/LOSTAT_2_0   per-level vector/status
//   ACK                      one-cycle pulse, IDENT_15_0 valid
//   IDENT_15_0               registered response word
//   CLR_HI, CLR_LO           one-cycle retire pulse for the acknowledged level
//   CLRVEC_2_0               vector being retired
module cga_intr_cntlr_vecack
    import cga_intr_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RESNAP = 3
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        REQ,
    input  logic        SEL,
    input  logic        HIF,
    input  logic        LOF,
    input  logic [2:0]  HIVEC_2_0,
    input  logic [2:0]  LOVEC_2_0,
    input  logic [2:0]  HISTAT_2_0,
    input  logic [2:0]  LOSTAT_2_0,
    output logic        ACK,
    output logic [15:0] IDENT_15_0,
    output logic        CLR_HI,
    output logic        CLR_LO,
    output logic [2:0]  CLRVEC_2_0
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  resnap_q, resnap_d;
    logic        unstable_q, unstable_d;
    logic [15:0] ident_q, ident_d;
    logic        ack_q, ack_d;
    logic        clr_hi_q, clr_hi_d;
    logic        clr_lo_q, clr_lo_d;
    logic [2:0]  clrvec_q, clrvec_d;
    logic        cap, new_lvl, match;
    logic        snap_lvl, snap_flag, live_flag;
    logic [2:0]  snap_vec, live_vec, live_stat;

    cga_intr_cntlr_vecack_snap u_snap (
        .clk_i       (MCLK),
        .rst_ni      (RESET_N),
        .cap_i       (cap),
        .new_i       (new_lvl),
        .sel_i       (SEL),
        .hif_i       (HIF),
        .lof_i       (LOF),
        .hivec_i     (HIVEC_2_0),
        .lovec_i     (LOVEC_2_0),
        .histat_i    (HISTAT_2_0),
        .lostat_i    (LOSTAT_2_0),
        .lvl_o       (snap_lvl),
        .flag_o      (snap_flag),
        .vec_o       (snap_vec),
        .live_flag_o (live_flag),
        .live_vec_o  (live_vec),
        .live_stat_o (live_stat),
        .match_o     (match)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resnap_d   = resnap_q;
        unstable_d = unstable_q;
        ident_d    = ident_q;
        cap        = 1'b0;
        new_lvl    = 1'b0;
        // ACK and CLR are registered from the state, so they lag DRIVE/CLEAR
        // by one edge and can never overlap.
        ack_d      = state_q == ST_DRIVE;
        clr_hi_d   = (state_q == ST_CLEAR) && snap_flag && snap_lvl;
        clr_lo_d   = (state_q == ST_CLEAR) && snap_flag && !snap_lvl;
        clrvec_d   = ((state_q == ST_CLEAR) && snap_flag) ? snap_vec : clrvec_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    cap        = 1'b1;
                    new_lvl    = 1'b1;
                    cnt_d      = 4'(SETTLE_CYC);
                    resnap_d   = 3'd0;
                    unstable_d = 1'b0;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!REQ) begin
                    state_d = ST_IDLE;
                end else if (!match) begin
                    cap = 1'b1;
                    if (resnap_q < 3'(MAX_RESNAP)) begin
                        cnt_d    = 4'(SETTLE_CYC);
                        resnap_d = resnap_q + 3'd1;
                    end else begin
                        // Out of retries: respond with the latest capture, marked unstable.
                        unstable_d = 1'b1;
                        ident_d    = make_ident(snap_lvl, live_flag, 1'b1, live_stat, live_vec);
                        state_d    = ST_DRIVE;
                    end
                end else if (cnt_q == 4'd1) begin
                    ident_d = make_ident(snap_lvl, live_flag, unstable_q, live_stat, live_vec);
                    state_d = ST_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DRIVE:    state_d = ST_CLEAR;
            ST_CLEAR:    state_d = ST_WAIT_REL;
            ST_WAIT_REL: state_d = REQ ? ST_WAIT_REL : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            resnap_q   <= 3'd0;
            unstable_q <= 1'b0;
            ident_q    <= 16'h0000;
            ack_q      <= 1'b0;
            clr_hi_q   <= 1'b0;
            clr_lo_q   <= 1'b0;
            clrvec_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resnap_q   <= resnap_d;
            unstable_q <= unstable_d;
            ident_q    <= ident_d;
            ack_q      <= ack_d;
            clr_hi_q   <= clr_hi_d;
            clr_lo_q   <= clr_lo_d;
            clrvec_q   <= clrvec_d;
        end
    end

    assign ACK        = ack_q;
    assign IDENT_15_0 = ident_q;
    assign CLR_HI     = clr_hi_q;
    assign CLR_LO     = clr_lo_q;
    assign CLRVEC_2_0 = clrvec_q;

endmodule

// File: tb/tb_cga_intr_cntlr_vecack.sv
// tb_cga_intr_cntlr_vecack: randomized self-checking bench with a transaction-level model.
module tb_cga_intr_cntlr_vecack;

    localparam int SETTLE = 2;
    localparam int MAXRS  = 3;

    logic        MCLK, RESET_N, REQ, SEL, HIF, LOF;
    logic [2:0]  HIVEC_2_0, LOVEC_2_0, HISTAT_2_0, LOSTAT_2_0;
    logic        ACK, CLR_HI, CLR_LO;
    logic [15:0] IDENT_15_0;
    logic [2:0]  CLRVEC_2_0;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  seq [64];
    int          seq_len;
    logic [15:0] prev_ident;

    cga_intr_cntlr_vecack #(.SETTLE_CYC(SETTLE), .MAX_RESNAP(MAXRS)) dut (
        .MCLK       (MCLK),
        .RESET_N    (RESET_N),
        .REQ        (REQ),
        .SEL        (SEL),
        .HIF        (HIF),
        .LOF        (LOF),
        .HIVEC_2_0  (HIVEC_2_0),
        .LOVEC_2_0  (LOVEC_2_0),
        .HISTAT_2_0 (HISTAT_2_0),
        .LOSTAT_2_0 (LOSTAT_2_0),
        .ACK        (ACK),
        .IDENT_15_0 (IDENT_15_0),
        .CLR_HI     (CLR_HI),
        .CLR_LO     (CLR_LO),
        .CLRVEC_2_0 (CLRVEC_2_0)
    );

    initial begin
        MCLK = 0;
        forever #5 MCLK = ~MCLK;
    end

    // Tuple encoding: [6]=flag, [5:3]=stat, [2:0]=vec of the selected level at edge i.
    function automatic logic [6:0] at(input int i);
        return (i < seq_len) ? seq[i] : seq[seq_len-1];
    endfunction

    // Walk the input history: a window of SETTLE unchanged edges finishes,
    // every change restarts the window, and the (MAXRS+1)-th change forces a response.
    task automatic predict(output int k_done, output bit forced);
        logic [6:0] snap;
        int start, rs;
        snap = at(0); start = 0; rs = 0; forced = 0; k_done = -1;
        for (int k = 1; k < 64 && k_done < 0; k++) begin
            if (at(k) != snap) begin
                snap = at(k);
                if (rs == MAXRS) begin
                    forced = 1;
                    k_done = k;
                end else begin
                    rs++;
                    start = k;
                end
            end else if (k - start == SETTLE) begin
                k_done = k;
            end
        end
    endtask

    task automatic apply(input logic sel, input int i);
        logic [6:0] v, r;
        v = at(i);
        r = 7'($urandom);
        if (sel) begin
            {HIF, HISTAT_2_0, HIVEC_2_0} = v;
            {LOF, LOSTAT_2_0, LOVEC_2_0} = r;
        end else begin
            {LOF, LOSTAT_2_0, LOVEC_2_0} = v;
            {HIF, HISTAT_2_0, HIVEC_2_0} = r;
        end
        SEL = (i == 0) ? sel : 1'($urandom);
    endtask

    task automatic run_txn(input logic sel, input int hold, input string name);
        int k_done, k_ack;
        bit forced;
        logic [6:0] fin;
        logic [15:0] exp_id, exp_now;
        logic e_hi, e_lo;
        predict(k_done, forced);
        fin    = at(k_done);
        exp_id = {sel, ~fin[6], forced, 6'b0, fin[5:3], 1'b0, fin[2:0]};
        k_ack  = k_done + 1;
        for (int i = 0; i <= k_ack + hold + 3; i++) begin
            @(negedge MCLK);
            REQ = (i <= k_ack + hold);
            apply(sel, i);
            @(posedge MCLK);
            #1;
            e_hi    = (i == k_ack + 1) && fin[6] && sel;
            e_lo    = (i == k_ack + 1) && fin[6] && !sel;
            exp_now = (i >= k_done) ? exp_id : prev_ident;
            checks += 4;
            if (ACK !== 1'(i == k_ack)) begin
                errors++;
                $display("FAIL %s ack edge %0d got %b exp %b", name, i, ACK, i == k_ack);
            end
            if (CLR_HI !== e_hi) begin
                errors++;
                $display("FAIL %s clr_hi edge %0d got %b exp %b", name, i, CLR_HI, e_hi);
            end
            if (CLR_LO !== e_lo) begin
                errors++;
                $display("FAIL %s clr_lo edge %0d got %b exp %b", name, i, CLR_LO, e_lo);
            end
            if (IDENT_15_0 !== exp_now) begin
                errors++;
                $display("FAIL %s ident edge %0d got %h exp %h", name, i, IDENT_15_0, exp_now);
            end
            if (e_hi || e_lo) begin
                checks++;
                if (CLRVEC_2_0 !== fin[2:0]) begin
                    errors++;
                    $display("FAIL %s clrvec got %0d exp %0d", name, CLRVEC_2_0, fin[2:0]);
                end
            end
        end
        prev_ident = exp_id;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({ACK, CLR_HI, CLR_LO, CLRVEC_2_0, IDENT_15_0} !== 22'd0) begin
            errors++;
            $display("FAIL %s outputs ack=%b hi=%b lo=%b vec=%0d id=%h exp all 0",
                     name, ACK, CLR_HI, CLR_LO, CLRVEC_2_0, IDENT_15_0);
        end
    endtask

    task automatic test_reset;
        RESET_N = 0; REQ = 0; SEL = 0;
        {HIF, LOF, HIVEC_2_0, LOVEC_2_0, HISTAT_2_0, LOSTAT_2_0} = '0;
        repeat (2) @(posedge MCLK);
        #1;
        check_zero("reset");
        @(negedge MCLK);
        RESET_N = 1;
        prev_ident = 16'h0000;
    endtask

    task automatic test_stable_hi;
        seq[0] = {1'b1, 3'd3, 3'd5}; seq_len = 1;
        run_txn(1'b1, 1, "stable_hi");
        checks++;
        if (IDENT_15_0 !== 16'h8035) begin
            errors++;
            $display("FAIL stable_hi_word got %h exp 8035", IDENT_15_0);
        end
    endtask

    task automatic test_empty_lo;
        seq[0] = 7'd0; seq_len = 1;
        run_txn(1'b0, 0, "empty_lo");
        checks++;
        if (IDENT_15_0 !== 16'h4000) begin
            errors++;
            $display("FAIL empty_lo_word got %h exp 4000", IDENT_15_0);
        end
    endtask

    task automatic test_glitch;
        // Vector changes exactly as each window would expire: worst-case latency.
        for (int j = 0; j < 9; j++) seq[j] = {1'b1, 3'd1, ((j / 2) % 2 == 1) ? 3'd6 : 3'd2};
        seq_len = 9;
        run_txn(1'b0, 2, "glitch_worst");
        // Toggle on every edge.
        for (int j = 0; j < 16; j++) seq[j] = {1'b1, 3'd4, (j % 2 == 1) ? 3'd7 : 3'd1};
        seq_len = 16;
        run_txn(1'b0, 0, "glitch_fast");
    endtask

    task automatic test_one_change;
        seq[0] = {1'b1, 3'd2, 3'd2};
        seq[1] = {1'b1, 3'd2, 3'd6};
        seq_len = 2;
        run_txn(1'b0, 0, "one_change");
        checks++;
        if (IDENT_15_0[13] !== 1'b0 || IDENT_15_0[2:0] !== 3'd6) begin
            errors++;
            $display("FAIL one_change_fields got %h exp unstable 0 vec 6", IDENT_15_0);
        end
    endtask

    task automatic test_abort_and_reset;
        bit seen;
        seq[0] = {1'b1, 3'd5, 3'd3}; seq_len = 1;
        @(negedge MCLK);
        REQ = 1;
        apply(1'b1, 0);
        @(posedge MCLK);
        @(negedge MCLK);
        REQ = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge MCLK);
            #1;
            checks++;
            if (ACK !== 0 || CLR_HI !== 0 || CLR_LO !== 0 || IDENT_15_0 !== prev_ident) begin
                errors++;
                $display("FAIL abort cyc %0d ack=%b hi=%b lo=%b id=%h exp 0 0 0 %h",
                         i, ACK, CLR_HI, CLR_LO, IDENT_15_0, prev_ident);
            end
        end
        @(negedge MCLK);
        REQ = 1;
        apply(1'b1, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge MCLK);
            #1;
            seen = ACK;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_clear ack timeout got 0 exp 1");
        end
        RESET_N = 0;
        #1;
        check_zero("reset_in_clear");
        @(negedge MCLK);
        REQ = 0;
        @(posedge MCLK);
        #1;
        check_zero("reset_held");
        @(negedge MCLK);
        RESET_N = 1;
        prev_ident = 16'h0000;
    endtask

    task automatic test_req_held;
        seq[0] = {1'b1, 3'd6, 3'd4}; seq_len = 1;
        run_txn(1'b1, 20, "req_held");
    endtask

    task automatic test_random;
        logic [6:0] cur;
        for (int t = 0; t < 25; t++) begin
            cur = 7'($urandom);
            seq_len = 12;
            for (int j = 0; j < 12; j++) begin
                if (j > 0 && $urandom_range(0, 2) == 0) cur = 7'($urandom);
                seq[j] = cur;
            end
            run_txn(1'($urandom), int'($urandom_range(0, 4)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_stable_hi();
        test_empty_lo();
        test_glitch();
        test_one_change();
        test_abort_and_reset();
        test_req_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
